// File: rtl/cam_stream_tx_if.sv
// Parallel camera bus plus the pixel-FIFO read port driven by the transmitter.
interface cam_stream_tx_if;
  logic [15:0] pix_q;
  logic        pix_empty;
  logic        pix_rdreq;
  logic        VSYNC_cam;
  logic        HREF_cam;
  logic [7:0]  data_cam;

  modport master (input pix_q, pix_empty, output pix_rdreq, VSYNC_cam, HREF_cam, data_cam);
  modport slave  (output pix_q, pix_empty, input pix_rdreq, VSYNC_cam, HREF_cam, data_cam);
endinterface

// File: rtl/cam_stream_tx.sv
// Camera emulator: streams RGB565 pixels (FIFO or colour bars) as OV7670-style
// VSYNC/HREF framing, high byte first.
module cam_stream_tx #(
  parameter int unsigned H_ACTIVE    = 640,
  parameter int unsigned V_ACTIVE    = 480,
  parameter int unsigned H_BLANK     = 144,
  parameter int unsigned VSYNC_LINES = 3,
  parameter int unsigned V_BP_LINES  = 17,
  parameter int unsigned V_FP_LINES  = 10
) (
  input  logic             PCLK_cam,
  input  logic             rst_n,
  input  logic             en,
  input  logic             pattern_en,
  cam_stream_tx_if.master  vif,
  output logic             frame_done,
  output logic             underrun
);

  localparam int unsigned LINE_LEN  = 2 * H_ACTIVE + H_BLANK;
  localparam int unsigned ACT_BYTES = 2 * H_ACTIVE;
  localparam int unsigned BAR_W     = H_ACTIVE / 8;
  localparam int unsigned H_W       = $clog2(LINE_LEN);
  localparam int unsigned V_W       = $clog2(VSYNC_LINES + V_BP_LINES + V_ACTIVE + V_FP_LINES + 1);
  localparam int unsigned B_W       = $clog2(BAR_W + 1);

  typedef enum logic [2:0] {ST_IDLE, ST_VSYNC, ST_VBP, ST_ACTIVE, ST_VFP} state_t;

  state_t           state_q, state_d;
  logic [H_W-1:0]   h_q, h_d;
  logic [V_W-1:0]   v_q, v_d;
  logic             pat_q, pat_d;
  logic             req_due_q, req_due_d;
  logic             got_q, got_d;
  logic [15:0]      hold_q, hold_d;
  logic [B_W-1:0]   bar_cnt_q, bar_cnt_d;
  logic [2:0]       bar_idx_q, bar_idx_d;
  logic             vsync_d, href_d, frame_done_d, underrun_d;
  logic [7:0]       data_d;
  logic [V_W-1:0]   state_lines;
  logic             line_end, last_line, enter_vsync, line_start_req, in_line_req;
  logic [15:0]      bar_color, pix_word;

  // A request is gated by the FIFO's empty flag in the same cycle.
  assign vif.pix_rdreq = req_due_q & ~vif.pix_empty;

  // Next-state, counters and next output values.
  always_comb begin
    state_d        = state_q;
    h_d            = h_q;
    v_d            = v_q;
    pat_d          = pat_q;
    hold_d         = hold_q;
    bar_cnt_d      = bar_cnt_q;
    bar_idx_d      = bar_idx_q;
    data_d         = 8'h00;
    bar_color      = 16'h0000;
    state_lines    = V_W'(1);

    case (state_q)
      ST_VSYNC:  state_lines = V_W'(VSYNC_LINES);
      ST_VBP:    state_lines = V_W'(V_BP_LINES);
      ST_ACTIVE: state_lines = V_W'(V_ACTIVE);
      ST_VFP:    state_lines = V_W'(V_FP_LINES);
      default:   state_lines = V_W'(1);
    endcase
    line_end  = (h_q == H_W'(LINE_LEN - 1));
    last_line = (v_q == state_lines - V_W'(1));

    if (state_q == ST_IDLE) begin
      if (en) begin
        state_d = ST_VSYNC;
        h_d     = '0;
        v_d     = '0;
      end
    end else begin
      h_d = line_end ? '0 : h_q + H_W'(1);
      if (line_end) begin
        if (last_line) begin
          v_d = '0;
          case (state_q)
            ST_VSYNC:  state_d = ST_VBP;
            ST_VBP:    state_d = ST_ACTIVE;
            ST_ACTIVE: state_d = ST_VFP;
            default:   state_d = en ? ST_VSYNC : ST_IDLE;
          endcase
        end else begin
          v_d = v_q + V_W'(1);
        end
      end
    end

    enter_vsync = (state_d == ST_VSYNC) && (state_q != ST_VSYNC);
    if (enter_vsync) pat_d = pattern_en;

    vsync_d      = (state_d == ST_VSYNC);
    href_d       = (state_d == ST_ACTIVE) && (h_d < H_W'(ACT_BYTES));
    frame_done_d = (state_d == ST_VFP) && (h_d == H_W'(LINE_LEN - 1)) &&
                   (v_d == V_W'(V_FP_LINES - 1));

    // Requests lead the high byte by two cycles, so the first one of a line
    // falls in the last blank slots of the previous line.
    line_start_req = (h_d == H_W'(LINE_LEN - 2)) &&
                     (((state_d == ST_VBP) && (v_d == V_W'(V_BP_LINES - 1))) ||
                      ((state_d == ST_ACTIVE) && (v_d != V_W'(V_ACTIVE - 1))));
    in_line_req    = (state_d == ST_ACTIVE) && !h_d[0] && (h_d < H_W'(ACT_BYTES - 2));
    req_due_d      = !pat_q && (line_start_req || in_line_req);
    got_d          = vif.pix_rdreq;
    underrun_d     = enter_vsync ? 1'b0 : (underrun | (req_due_q & vif.pix_empty));

    case (bar_idx_q)
      3'd0: bar_color = 16'hFFFF;
      3'd1: bar_color = 16'hFFE0;
      3'd2: bar_color = 16'h07FF;
      3'd3: bar_color = 16'h07E0;
      3'd4: bar_color = 16'hF81F;
      3'd5: bar_color = 16'hF800;
      3'd6: bar_color = 16'h001F;
      default: bar_color = 16'h0000;
    endcase
    pix_word = pat_q ? bar_color : (got_q ? vif.pix_q : 16'h0000);

    if (href_d) begin
      if (!h_d[0]) begin
        data_d = pix_word[15:8];
        hold_d = pix_word;
      end else begin
        data_d = hold_q[7:0];
        if (bar_cnt_q == B_W'(BAR_W - 1)) begin
          bar_cnt_d = '0;
          bar_idx_d = bar_idx_q + 3'd1;
        end else begin
          bar_cnt_d = bar_cnt_q + B_W'(1);
        end
      end
    end else begin
      bar_cnt_d = '0;
      bar_idx_d = '0;
    end
  end

  // State, counters and registered outputs.
  always_ff @(posedge PCLK_cam or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      h_q           <= '0;
      v_q           <= '0;
      pat_q         <= 1'b0;
      req_due_q     <= 1'b0;
      got_q         <= 1'b0;
      hold_q        <= 16'h0000;
      bar_cnt_q     <= '0;
      bar_idx_q     <= '0;
      vif.VSYNC_cam <= 1'b0;
      vif.HREF_cam  <= 1'b0;
      vif.data_cam  <= 8'h00;
      frame_done    <= 1'b0;
      underrun      <= 1'b0;
    end else begin
      state_q       <= state_d;
      h_q           <= h_d;
      v_q           <= v_d;
      pat_q         <= pat_d;
      req_due_q     <= req_due_d;
      got_q         <= got_d;
      hold_q        <= hold_d;
      bar_cnt_q     <= bar_cnt_d;
      bar_idx_q     <= bar_idx_d;
      vif.VSYNC_cam <= vsync_d;
      vif.HREF_cam  <= href_d;
      vif.data_cam  <= data_d;
      frame_done    <= frame_done_d;
      underrun      <= underrun_d;
    end
  end

endmodule

// File: tb/tb_cam_stream_tx.sv
// Directed bench for cam_stream_tx with a small frame (20-cycle lines, 100-cycle frames).
module tb_cam_stream_tx;

  logic PCLK_cam = 1'b0;
  logic rst_n;
  logic en;
  logic pattern_en;
  logic frame_done;
  logic underrun;

  int total = 0;
  int bad   = 0;
  int fifo_idx = 0;

  logic [15:0] bars [8] = '{16'hFFFF, 16'hFFE0, 16'h07FF, 16'h07E0,
                            16'hF81F, 16'hF800, 16'h001F, 16'h0000};

  cam_stream_tx_if cif ();

  cam_stream_tx #(
    .H_ACTIVE(8), .V_ACTIVE(2), .H_BLANK(4),
    .VSYNC_LINES(1), .V_BP_LINES(1), .V_FP_LINES(1)
  ) dut (
    .PCLK_cam   (PCLK_cam),
    .rst_n      (rst_n),
    .en         (en),
    .pattern_en (pattern_en),
    .vif        (cif),
    .frame_done (frame_done),
    .underrun   (underrun)
  );

  always #5 PCLK_cam = ~PCLK_cam;

  // FIFO model: returns 0x1000 + n for the n-th accepted read, one cycle later.
  always @(posedge PCLK_cam) begin
    if (cif.pix_rdreq) begin
      cif.pix_q <= 16'(32'h1000 + fifo_idx);
      fifo_idx  <= fifo_idx + 1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [11:0] obs_vec();
    return {cif.VSYNC_cam, cif.HREF_cam, cif.pix_rdreq, frame_done, cif.data_cam};
  endfunction

  // mode 0 = FIFO with data, 1 = FIFO empty, 2 = colour bars
  function automatic logic [11:0] exp_vec(input int mode, input int k, input int base);
    logic vs, hr, rq, fd;
    logic [7:0] d;
    logic [15:0] px;
    int l, h, kk;
    vs = (k < 20);
    fd = (k == 99);
    hr = 1'b0;
    rq = 1'b0;
    d  = 8'h00;
    if (k >= 40 && k < 80) begin
      l = (k - 40) / 20;
      h = (k - 40) % 20;
      if (h < 16) begin
        hr = 1'b1;
        if (mode == 0)      px = 16'(32'h1000 + base + l * 8 + h / 2);
        else if (mode == 2) px = bars[h / 2];
        else                px = 16'h0000;
        d = (h % 2 == 0) ? px[15:8] : px[7:0];
      end
    end
    kk = k + 2;
    if (mode == 0 && kk >= 40 && kk < 80 && ((kk - 40) % 20) < 16 && ((kk - 40) % 2) == 0)
      rq = 1'b1;
    return {vs, hr, rq, fd, d};
  endfunction

  // Called at the negedge of frame cycle 0; returns at the negedge of cycle 100.
  task automatic check_frame(input int mode, input int drop_at);
    int base;
    int nrq;
    int nfd;
    base = fifo_idx;
    nrq  = 0;
    nfd  = 0;
    for (int k = 0; k < 100; k++) begin
      chk($sformatf("m%0d_cyc%0d", mode, k), 32'(obs_vec()), 32'(exp_vec(mode, k, base)));
      if (mode == 1) begin
        if (k < 38)       chk($sformatf("ur_low_cyc%0d", k), 32'(underrun), 32'd0);
        else if (k >= 56) chk($sformatf("ur_high_cyc%0d", k), 32'(underrun), 32'd1);
      end else begin
        chk($sformatf("ur_zero_m%0d_cyc%0d", mode, k), 32'(underrun), 32'd0);
      end
      nrq += int'(cif.pix_rdreq);
      nfd += int'(frame_done);
      // pattern selection must stay latched for the whole frame
      if (mode == 2 && k == 0) pattern_en = 1'b0;
      if (k == drop_at) en = 1'b0;
      @(negedge PCLK_cam);
    end
    chk($sformatf("rdreq_count_m%0d", mode), 32'(nrq), (mode == 0) ? 32'd16 : 32'd0);
    chk($sformatf("done_count_m%0d", mode), 32'(nfd), 32'd1);
  endtask

  task automatic start_frame(input bit hold);
    en = 1'b1;
    @(negedge PCLK_cam);
    if (!hold) en = 1'b0;
  endtask

  initial begin
    int noisy;
    rst_n         = 1'b0;
    en            = 1'b0;
    pattern_en    = 1'b0;
    cif.pix_empty = 1'b0;

    repeat (3) @(negedge PCLK_cam);
    chk("reset_outputs", 32'({obs_vec(), underrun}), 32'd0);
    rst_n = 1'b1;
    noisy = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge PCLK_cam);
      if ({obs_vec(), underrun} != 13'd0) noisy++;
    end
    chk("idle_quiet_200", 32'(noisy), 32'd0);

    // single FIFO frame from a one-cycle en pulse
    start_frame(1'b0);
    check_frame(0, -1);
    chk("fifo_then_idle", 32'(obs_vec()), 32'd0);
    repeat (5) @(negedge PCLK_cam);
    chk("fifo_idle_later", 32'(obs_vec()), 32'd0);

    // empty FIFO throughout
    cif.pix_empty = 1'b1;
    start_frame(1'b0);
    check_frame(1, -1);
    chk("underrun_sticky_idle", 32'(underrun), 32'd1);

    // colour bars; underrun from the previous frame clears at VSYNC
    pattern_en = 1'b1;
    start_frame(1'b0);
    check_frame(2, -1);
    cif.pix_empty = 1'b0;

    // back-to-back frames, en dropped at cycle 30 of the second
    start_frame(1'b1);
    check_frame(0, -1);
    check_frame(0, 30);
    chk("stop_then_idle", 32'(obs_vec()), 32'd0);
    repeat (50) @(negedge PCLK_cam);
    chk("stop_idle_later", 32'(obs_vec()), 32'd0);

    // reset during the 5th active byte of the first line
    start_frame(1'b1);
    repeat (44) @(negedge PCLK_cam);
    chk("pre_reset_href", 32'({cif.HREF_cam, cif.data_cam}), 32'h110);
    rst_n = 1'b0;
    #1;
    chk("reset_midline_drop", 32'({obs_vec(), underrun}), 32'd0);
    @(negedge PCLK_cam);
    rst_n = 1'b1;
    @(negedge PCLK_cam);
    check_frame(0, 30);
    chk("after_restart_idle", 32'(obs_vec()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
